// File: rtl/pulse_seq_pkg.sv
// Shared state encoding, default widths and helpers for the pulse sequencer.
// PULSE_SEQ_NUTATION_EN adds the nutation pulse/delay states ahead of pulse 1.
package pulse_seq_pkg;

   localparam int PER_W_DEF    = 32;
   localparam int SEG_W_DEF    = 16;
   localparam int BL_W_DEF     = 8;
   localparam int CPMG_MAX_DEF = 255;
   localparam int MIN_PER      = 2;

   typedef enum logic [3:0] {
      S_LOAD,
`ifdef PULSE_SEQ_NUTATION_EN
      S_NUT,
      S_NDEL,
`endif
      S_P1,
      S_DEL,
      S_P2,
      S_CPDEL,
      S_TAIL,
      S_WAIT
   } state_t;

   // States that drive the RF gate.
   function automatic logic is_pulse(input state_t s);
      logic r;
      r = 1'b0;
      case (s)
`ifdef PULSE_SEQ_NUTATION_EN
         S_NUT: r = 1'b1;
`endif
         S_P1:  r = 1'b1;
         S_P2:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // States inside the pulse train; also the inhibit window when enabled.
   function automatic logic is_busy(input state_t s);
      logic r;
      r = 1'b0;
      case (s)
`ifdef PULSE_SEQ_NUTATION_EN
         S_NUT:   r = 1'b1;
         S_NDEL:  r = 1'b1;
`endif
         S_P1:    r = 1'b1;
         S_DEL:   r = 1'b1;
         S_P2:    r = 1'b1;
         S_CPDEL: r = 1'b1;
         S_TAIL:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_timer.sv
// Loadable down-counter shared by all sequence segments; done is high while
// the count sits at zero, which marks the last cycle of the current segment.
module seg_timer #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign done = (cnt_reg == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Per-period RF gate sequencer: pulse 1, delay, pulse 2, optional CPMG train,
// plus inhibit and sync. Define PULSE_SEQ_NUTATION_EN for the nutation pre-pulse.
module pulse_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int PER_W    = PER_W_DEF,
   parameter int SEG_W    = SEG_W_DEF,
   parameter int BL_W     = BL_W_DEF,
   parameter int CPMG_MAX = CPMG_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PER_W-1:0] per,
   input  logic [SEG_W-1:0] p1wid,
   input  logic [SEG_W-1:0] del,
   input  logic [SEG_W-1:0] p2wid,
   input  logic             cp,
   input  logic [BL_W-1:0]  p_bl,
   input  logic             bl,
   input  logic             rxd,
`ifdef PULSE_SEQ_NUTATION_EN
   input  logic [7:0]       nut_w,
   input  logic [15:0]      nut_d,
`endif
   output logic             pulse,
   output logic             inhib,
   output logic             sync,
   output logic             busy,
   output logic             upd_pend
);

   localparam int TW    = SEG_W + 1;
   localparam int REP_W = (CPMG_MAX < 1) ? 1 : $clog2(CPMG_MAX + 1);

   state_t           state_reg, state_next, tgt;
   logic [PER_W-1:0] cnt_reg, cnt_next;
   logic [PER_W-1:0] per_s_reg;
   logic [SEG_W-1:0] p1wid_s_reg, del_s_reg, p2wid_s_reg;
   logic [BL_W-1:0]  p_bl_s_reg;
   logic             cp_s_reg, bl_s_reg;
   logic [REP_W-1:0] rep_reg;
   logic             rxd_d_reg, upd_pend_reg;
   logic             pulse_reg, inhib_reg, sync_reg;

   logic [SEG_W-1:0] p1wid_cur, del_cur, p2wid_cur;
   logic [BL_W-1:0]  p_bl_cur;
   logic             cp_cur;
   logic             load_cfg, wrap, enter, rep_inc, seg_load, seg_done;
   logic [TW-1:0]    seg_len, seg_val;

`ifdef PULSE_SEQ_NUTATION_EN
   logic [7:0]       nut_w_s_reg, nut_w_cur;
   logic [15:0]      nut_d_s_reg, nut_d_cur;
   localparam state_t FIRST_SEG = S_NUT;
`else
   localparam state_t FIRST_SEG = S_P1;
`endif

   // In the load cycle the shadows are being written, so decisions taken there
   // must see the incoming values rather than the stale shadows.
   assign load_cfg  = (state_reg == S_LOAD);
   assign p1wid_cur = load_cfg ? p1wid : p1wid_s_reg;
   assign del_cur   = load_cfg ? del   : del_s_reg;
   assign p2wid_cur = load_cfg ? p2wid : p2wid_s_reg;
   assign p_bl_cur  = load_cfg ? p_bl  : p_bl_s_reg;
   assign cp_cur    = load_cfg ? cp    : cp_s_reg;
`ifdef PULSE_SEQ_NUTATION_EN
   assign nut_w_cur = load_cfg ? nut_w : nut_w_s_reg;
   assign nut_d_cur = load_cfg ? nut_d : nut_d_s_reg;
`endif

   assign wrap     = !load_cfg && (cnt_reg == per_s_reg - PER_W'(1));
   assign cnt_next = wrap ? '0 : cnt_reg + PER_W'(1);
   assign seg_val  = seg_len - TW'(1);

   always_comb begin
      state_next = state_reg;
      tgt        = state_reg;
      enter      = 1'b0;
      rep_inc    = 1'b0;
      seg_len    = '0;
      seg_load   = 1'b0;

      case (state_reg)
         S_LOAD: begin
            tgt   = FIRST_SEG;
            enter = 1'b1;
         end
`ifdef PULSE_SEQ_NUTATION_EN
         S_NUT:   if (seg_done) begin tgt = S_NDEL; enter = 1'b1; end
         S_NDEL:  if (seg_done) begin tgt = S_P1;   enter = 1'b1; end
`endif
         S_P1:    if (seg_done) begin tgt = S_DEL;  enter = 1'b1; end
         S_DEL:   if (seg_done) begin tgt = S_P2;   enter = 1'b1; end
         S_P2: begin
            if (seg_done) begin
               enter = 1'b1;
               if (cp_cur && (rep_reg < REP_W'(CPMG_MAX))) begin
                  tgt     = S_CPDEL;
                  rep_inc = 1'b1;
               end else begin
                  tgt = S_TAIL;
               end
            end
         end
         S_CPDEL: if (seg_done) begin tgt = S_P2;   enter = 1'b1; end
         S_TAIL:  if (seg_done) begin tgt = S_WAIT; enter = 1'b1; end
         default: ;
      endcase

      // Zero-length segments occupy no cycles; fall through to the next one.
      if (enter) begin
`ifdef PULSE_SEQ_NUTATION_EN
         if (tgt == S_NUT  && nut_w_cur == '0) tgt = S_P1;
         if (tgt == S_NDEL && nut_d_cur == '0) tgt = S_P1;
`endif
         if (tgt == S_P1    && p1wid_cur == '0) tgt = S_DEL;
         if (tgt == S_DEL   && del_cur   == '0) tgt = S_P2;
         if (tgt == S_CPDEL && del_cur   == '0) tgt = S_P2;
         if (tgt == S_P2    && p2wid_cur == '0) tgt = S_TAIL;
         if (tgt == S_TAIL  && p_bl_cur  == '0) tgt = S_WAIT;

         case (tgt)
`ifdef PULSE_SEQ_NUTATION_EN
            S_NUT:   seg_len = TW'(nut_w_cur);
            S_NDEL:  seg_len = TW'(nut_d_cur);
`endif
            S_P1:    seg_len = TW'(p1wid_cur);
            S_DEL:   seg_len = TW'(del_cur);
            S_P2:    seg_len = TW'(p2wid_cur);
            S_CPDEL: seg_len = {del_cur, 1'b0};
            S_TAIL:  seg_len = TW'(p_bl_cur);
            default: seg_len = '0;
         endcase

         state_next = tgt;
         seg_load   = (tgt != S_WAIT);
      end

      // The period boundary wins over whatever segment is in progress.
      if (wrap) begin
         state_next = S_LOAD;
         seg_load   = 1'b0;
         rep_inc    = 1'b0;
      end
   end

   seg_timer #(
      .W        (TW)
   ) u_seg_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seg_load),
      .load_val (seg_val),
      .done     (seg_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_s_reg   <= PER_W'(MIN_PER);
         p1wid_s_reg <= '0;
         del_s_reg   <= '0;
         p2wid_s_reg <= '0;
         p_bl_s_reg  <= '0;
         cp_s_reg    <= 1'b0;
         bl_s_reg    <= 1'b0;
`ifdef PULSE_SEQ_NUTATION_EN
         nut_w_s_reg <= '0;
         nut_d_s_reg <= '0;
`endif
      end else if (load_cfg) begin
         per_s_reg   <= (per < PER_W'(MIN_PER)) ? PER_W'(MIN_PER) : per;
         p1wid_s_reg <= p1wid;
         del_s_reg   <= del;
         p2wid_s_reg <= p2wid;
         p_bl_s_reg  <= p_bl;
         cp_s_reg    <= cp;
         bl_s_reg    <= bl;
`ifdef PULSE_SEQ_NUTATION_EN
         nut_w_s_reg <= nut_w;
         nut_d_s_reg <= nut_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_LOAD;
         cnt_reg      <= '0;
         rep_reg      <= '0;
         rxd_d_reg    <= 1'b0;
         upd_pend_reg <= 1'b0;
         pulse_reg    <= 1'b0;
         inhib_reg    <= 1'b0;
         sync_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rxd_d_reg <= rxd;
         if (load_cfg) begin
            rep_reg <= '0;
         end else if (rep_inc) begin
            rep_reg <= rep_reg + REP_W'(1);
         end
         if (load_cfg) begin
            upd_pend_reg <= 1'b0;
         end else if (rxd && !rxd_d_reg) begin
            upd_pend_reg <= 1'b1;
         end
         pulse_reg <= is_pulse(state_reg);
         inhib_reg <= bl_s_reg & is_busy(state_reg);
         sync_reg  <= load_cfg;
      end
   end

   assign pulse    = pulse_reg;
   assign inhib    = inhib_reg;
   assign sync     = sync_reg;
   assign busy     = is_busy(state_reg);
   assign upd_pend = upd_pend_reg;

endmodule
